vjtag_rx_deframer: RTL and testbench
====================================

Name: vjtag_rx_deframer

Overview:
Receive-direction counterpart to the JTAG transmit FSM. Accepts a byte stream arriving from the host over the virtual JTAG link, already in the sysclk domain. It hunts for frame sync, checks length and checksum, and buffers the payload speculatively in an internal FIFO. Only frames that pass all checks become visible to the application side; bad frames are rolled back and reported.

Parameters:
DEPTH, 16, payload FIFO entries; power of 2; must be >= MAX_LEN.
MAX_LEN, 16, maximum legal payload length in bytes (1..255).
TIMEOUT, 1000, idle cycles allowed between accepted bytes inside a frame before it is aborted.

Ports:
clk_i  in  1  system clock (sysclk).
reset_i  in  1  synchronous reset, active-high.
rx_valid_i  in  1  host byte available.
rx_data_i  in  8  host byte.
rx_ready_o  out  1  block accepts the byte; a transfer occurs when rx_valid_i && rx_ready_o.
pkt_data_o  out  8  payload byte at the FIFO head (show-ahead).
pkt_last_o  out  1  head byte is the final byte of its frame.
pkt_valid_o  out  1  committed payload available.
pkt_ready_i  in  1  application consumes the head byte when pkt_valid_o && pkt_ready_i.
pkt_done_o  out  1  one-cycle pulse when a good frame is committed.
err_o  out  1  one-cycle pulse when a frame is rejected.
err_code_o  out  2  last error: 0 none, 1 bad length, 2 checksum, 3 timeout.
frame_count_o  out  16  count of good frames; wraps 0xFFFF->0.

Behaviour:
- Frame format: SYNC=0xA5, LEN, LEN payload bytes, CHK. CHK = XOR of LEN and all payload bytes.
- Reset (sync, dominant over all other events): state=HUNT; all pointers 0; FIFO empty; rx_ready_o=1; pkt_valid_o=0; pkt_last_o=0; pkt_done_o=0; err_o=0; err_code_o=0; frame_count_o=0; timeout counter 0. Reset mid-frame discards the partial frame and any committed data.
- FIFO: 9-bit entries {last, data}. Three pointers of log2(DEPTH)+1 bits: rd_ptr, wr_ptr (tentative), cm_ptr (committed).
  - pkt_valid_o = (cm_ptr != rd_ptr); pkt_data_o and pkt_last_o read combinationally from mem[rd_ptr].
  - The reader never passes cm_ptr.
  - Full = (wr_ptr - rd_ptr == DEPTH).
- State machine (advances only on accepted bytes, except timeout):
  - HUNT: byte==0xA5 -> LEN; any other byte is discarded silently, with no error.
  - LEN: LEN==0 or LEN>MAX_LEN -> err code 1, go to HUNT. Otherwise latch remaining=LEN, chk=LEN, go to PAYLOAD.
  - PAYLOAD: write {remaining==1, byte} at wr_ptr, wr_ptr++, chk^=byte, remaining--. Go to CHECK after the last byte.
  - CHECK: byte==chk -> cm_ptr<=wr_ptr, pkt_done_o pulse, frame_count_o++. Otherwise wr_ptr<=cm_ptr (rollback), err code 2. Either way go to HUNT.
- rx_ready_o = 0 only in PAYLOAD while full; 1 in all other states. DEPTH>=MAX_LEN guarantees progress once the reader drains committed data.
- Timeout: applies in LEN/PAYLOAD/CHECK.
  - Counter clears on each accepted byte and on entry to HUNT.
  - Increments each cycle with no accepted byte; holds while rx_ready_o=0 (backpressure never times out).
  - Reaching TIMEOUT -> rollback wr_ptr<=cm_ptr, err code 3, go to HUNT, with err_o pulsing that cycle.
- err_o pulses one cycle coincident with the err_code_o update. err_code_o holds until the next error.
- Latency: a frame's first byte appears on pkt_valid_o in the cycle after the CHK byte is accepted.
- Simultaneous events:
  - A read in the same cycle as a commit or rollback is legal; the read affects rd_ptr only.
  - A write plus a read in the same cycle is legal; the full calculation uses the registered pointers.

Test Plan:
- Good frame: A5 03 11 22 33 03 -> pkt_done_o pulse; output 11, 22, 33 with pkt_last_o on 33; frame_count_o=1; err_o never asserted.
- Bad checksum: A5 03 11 22 33 04 -> err_o pulse, err_code_o=2; pkt_valid_o stays 0; a following good frame A5 01 5A 5B delivers only 5A.
- Bad length: A5 00, then A5 11 (17>MAX_LEN) -> two err_o pulses, err_code_o=1; no FIFO writes; next A5 01 5A 5B is accepted.
- Sync hunt: 00 FF 3C A5 01 5A 5B -> no errors; single byte 5A with last=1; frame_count_o=1.
- Backpressure: pkt_ready_i=0; send a 16-byte good frame, then a second frame.
  - rx_ready_o drops on the second frame's first payload byte and no timeout occurs for 5000 cycles.
  - Raising pkt_ready_i then delivers all 32 bytes in order, with last on bytes 16 and 32.
- Timeout and reset: A5 02 11, then idle -> err code 3 exactly TIMEOUT cycles after the 11 byte; FIFO empty. Separately, reset_i asserted after A5 02 11 -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/vjtag_rx_deframer.sv
// Receive-side deframer for the virtual JTAG link: hunts SYNC, checks LEN/CHK and
// buffers payload speculatively so only frames that pass every check reach the reader.
module vjtag_rx_deframer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic [7:0]  pkt_data_o,
  output logic        pkt_last_o,
  output logic        pkt_valid_o,
  input  logic        pkt_ready_i,
  output logic        pkt_done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [15:0] frame_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  SyncByte = 8'hA5;
  localparam logic [7:0]  MaxLen   = 8'(MAX_LEN);

  typedef enum logic [1:0] {StHunt, StLen, StPayload, StCheck} state_e;

  state_e          state_q;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q, cm_ptr_q;
  logic [8:0]      mem_q [DEPTH];
  logic [7:0]      remaining_q, chk_q;
  logic [TW-1:0]   tmo_q;
  logic            pkt_done_q, err_q;
  logic [1:0]      err_code_q;
  logic [15:0]     frame_count_q;

  logic [PW-1:0]   fill;
  logic            full, rx_fire, rd_fire, mem_we, tmo_hit;
  logic [8:0]      head;

  assign fill        = wr_ptr_q - rd_ptr_q;
  assign full        = (fill == PW'(DEPTH));
  assign rx_ready_o  = !((state_q == StPayload) && full);
  assign rx_fire     = rx_valid_i && rx_ready_o;
  assign pkt_valid_o = (cm_ptr_q != rd_ptr_q);
  assign rd_fire     = pkt_valid_o && pkt_ready_i;
  assign mem_we      = rx_fire && (state_q == StPayload) && !reset_i;

  // Counter holds under backpressure, so a stalled writer never times out.
  assign tmo_hit = (state_q != StHunt) && !rx_fire && rx_ready_o &&
                   (tmo_q == TW'(TIMEOUT - 1));

  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign pkt_data_o    = head[7:0];
  assign pkt_last_o    = pkt_valid_o && head[8];
  assign pkt_done_o    = pkt_done_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;
  assign frame_count_o = frame_count_q;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {(remaining_q == 8'd1), rx_data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StHunt;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cm_ptr_q      <= '0;
      remaining_q   <= '0;
      chk_q         <= '0;
      tmo_q         <= '0;
      pkt_done_q    <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'd0;
      frame_count_q <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      err_q      <= 1'b0;

      if (rd_fire) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end

      if ((state_q == StHunt) || rx_fire) begin
        tmo_q <= '0;
      end else if (rx_ready_o) begin
        tmo_q <= tmo_q + TW'(1);
      end

      if (tmo_hit) begin
        wr_ptr_q   <= cm_ptr_q;
        err_q      <= 1'b1;
        err_code_q <= 2'd3;
        tmo_q      <= '0;
        state_q    <= StHunt;
      end else if (rx_fire) begin
        unique case (state_q)
          StHunt: begin
            if (rx_data_i == SyncByte) begin
              state_q <= StLen;
            end
          end
          StLen: begin
            if ((rx_data_i == 8'd0) || (rx_data_i > MaxLen)) begin
              err_q      <= 1'b1;
              err_code_q <= 2'd1;
              state_q    <= StHunt;
            end else begin
              remaining_q <= rx_data_i;
              chk_q       <= rx_data_i;
              state_q     <= StPayload;
            end
          end
          StPayload: begin
            wr_ptr_q    <= wr_ptr_q + PW'(1);
            chk_q       <= chk_q ^ rx_data_i;
            remaining_q <= remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              state_q <= StCheck;
            end
          end
          StCheck: begin
            if (rx_data_i == chk_q) begin
              cm_ptr_q      <= wr_ptr_q;
              pkt_done_q    <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
            end else begin
              wr_ptr_q   <= cm_ptr_q;
              err_q      <= 1'b1;
              err_code_q <= 2'd2;
            end
            state_q <= StHunt;
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vjtag_rx_deframer.sv
// Directed bench for vjtag_rx_deframer: good/bad frames, sync hunt, backpressure,
// timeout and mid-frame reset, with hand-computed expectations.
module tb_vjtag_rx_deframer;

  localparam int unsigned Depth   = 16;
  localparam int unsigned MaxLen  = 16;
  localparam int unsigned Timeout = 1000;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [8:0] ent_q_t[$];

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_ready_o;
  logic [7:0]  pkt_data_o;
  logic        pkt_last_o;
  logic        pkt_valid_o;
  logic        pkt_ready_i = 1'b0;
  logic        pkt_done_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [15:0] frame_count_o;

  vjtag_rx_deframer #(
    .DEPTH  (Depth),
    .MAX_LEN(MaxLen),
    .TIMEOUT(Timeout)
  ) u_dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rx_valid_i   (rx_valid_i),
    .rx_data_i    (rx_data_i),
    .rx_ready_o   (rx_ready_o),
    .pkt_data_o   (pkt_data_o),
    .pkt_last_o   (pkt_last_o),
    .pkt_valid_o  (pkt_valid_o),
    .pkt_ready_i  (pkt_ready_i),
    .pkt_done_o   (pkt_done_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o),
    .frame_count_o(frame_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errs = 0;
  int err_pulses = 0;
  logic [8:0] cap_q[$];

  // Capture handshakes and error pulses at the edge where they take effect.
  always @(posedge clk_i) begin
    if (!reset_i && pkt_valid_o && pkt_ready_i) cap_q.push_back({pkt_last_o, pkt_data_o});
    if (err_o) err_pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    cap_q.delete();
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    while (!rx_ready_o && n < 200) begin
      step();
      n++;
    end
    if (!rx_ready_o) check_eq("send_ready_wait", {31'd0, rx_ready_o}, 32'd1);
    step();
    rx_valid_i = 1'b0;
  endtask

  task automatic send_seq(input byte_q_t s);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic expect_cap(input string tag, input ent_q_t exp);
    check_eq({tag, "_count"}, cap_q.size(), exp.size());
    foreach (exp[i]) begin
      check_eq($sformatf("%s_byte%0d", tag, i),
               (i < cap_q.size()) ? {23'd0, cap_q[i]} : 32'hFFFF_FFFF, {23'd0, exp[i]});
    end
  endtask

  initial begin
    byte_q_t seq;
    ent_q_t  exp;
    int      e0;
    int      hi_cnt;
    int      early;

    step();
    do_reset();
    check_eq("rst_rx_ready", rx_ready_o, 1);
    check_eq("rst_pkt_valid", pkt_valid_o, 0);
    check_eq("rst_pkt_last", pkt_last_o, 0);
    check_eq("rst_done", pkt_done_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_err_code", err_code_o, 0);
    check_eq("rst_frame_count", frame_count_o, 0);

    // Good frame
    pkt_ready_i = 1'b1;
    e0 = err_pulses;
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    send_seq(seq);
    check_eq("good_no_valid_before_chk", pkt_valid_o, 0);
    send(8'h03);
    check_eq("good_done", pkt_done_o, 1);
    check_eq("good_valid_latency", pkt_valid_o, 1);
    check_eq("good_frame_count", frame_count_o, 1);
    repeat (5) step();
    check_eq("good_done_cleared", pkt_done_o, 0);
    exp = '{9'h011, 9'h022, 9'h133};
    expect_cap("good", exp);
    check_eq("good_no_err", err_pulses - e0, 0);

    // Bad checksum then a good one-byte frame
    do_reset();
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    send_seq(seq);
    check_eq("chk_err", err_o, 1);
    check_eq("chk_err_code", err_code_o, 2);
    check_eq("chk_no_valid", pkt_valid_o, 0);
    seq = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
    send_seq(seq);
    check_eq("chk_err_code_held", err_code_o, 2);
    repeat (3) step();
    exp = '{9'h15A};
    expect_cap("chk_next", exp);
    check_eq("chk_frame_count", frame_count_o, 1);

    // Bad lengths: zero and MAX_LEN+1
    do_reset();
    e0 = err_pulses;
    seq = '{8'hA5, 8'h00};
    send_seq(seq);
    check_eq("len0_err", err_o, 1);
    check_eq("len0_code", err_code_o, 1);
    seq = '{8'hA5, 8'h11};
    send_seq(seq);
    check_eq("len17_err", err_o, 1);
    check_eq("len17_code", err_code_o, 1);
    seq = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
    send_seq(seq);
    repeat (3) step();
    check_eq("len_err_pulses", err_pulses - e0, 2);
    exp = '{9'h15A};
    expect_cap("len_next", exp);
    check_eq("len_frame_count", frame_count_o, 1);

    // Sync hunt through garbage
    do_reset();
    e0 = err_pulses;
    seq = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h5A, 8'h5B};
    send_seq(seq);
    repeat (3) step();
    check_eq("hunt_no_err", err_pulses - e0, 0);
    exp = '{9'h15A};
    expect_cap("hunt", exp);
    check_eq("hunt_frame_count", frame_count_o, 1);

    // Backpressure: payload 0x40..0x4F and 0x80..0x8F, both XOR to 0 so CHK = LEN = 0x10
    do_reset();
    pkt_ready_i = 1'b0;
    e0 = err_pulses;
    seq = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) seq.push_back(8'h40 + 8'(i));
    seq.push_back(8'h10);
    send_seq(seq);
    check_eq("bp_first_committed", pkt_valid_o, 1);
    seq = '{8'hA5, 8'h10};
    send_seq(seq);
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h80;
    check_eq("bp_ready_low", rx_ready_o, 0);
    hi_cnt = 0;
    repeat (5000) begin
      step();
      if (rx_ready_o) hi_cnt++;
    end
    check_eq("bp_ready_stayed_low", hi_cnt, 0);
    check_eq("bp_no_timeout", err_pulses - e0, 0);
    pkt_ready_i = 1'b1;
    seq = '{};
    for (int i = 0; i < 16; i++) seq.push_back(8'h80 + 8'(i));
    seq.push_back(8'h10);
    send_seq(seq);
    repeat (40) step();
    exp = '{};
    for (int i = 0; i < 16; i++) exp.push_back({(i == 15), 8'h40 + 8'(i)});
    for (int i = 0; i < 16; i++) exp.push_back({(i == 15), 8'h80 + 8'(i)});
    expect_cap("bp", exp);
    check_eq("bp_frame_count", frame_count_o, 2);

    // Timeout exactly Timeout cycles after the last accepted byte
    do_reset();
    seq = '{8'hA5, 8'h02, 8'h11};
    send_seq(seq);
    early = 0;
    for (int k = 1; k < int'(Timeout); k++) begin
      step();
      if (err_o) early++;
    end
    step();
    check_eq("tmo_no_early_err", early, 0);
    check_eq("tmo_err", err_o, 1);
    check_eq("tmo_code", err_code_o, 3);
    check_eq("tmo_fifo_empty", pkt_valid_o, 0);
    step();
    check_eq("tmo_err_one_cycle", err_o, 0);
    check_eq("tmo_code_held", err_code_o, 3);

    // Reset mid-frame with committed data and a latched error code
    do_reset();
    pkt_ready_i = 1'b0;
    seq = '{8'hA5, 8'h01, 8'h5A, 8'h5B, 8'hA5, 8'h00, 8'hA5, 8'h02, 8'h11};
    send_seq(seq);
    check_eq("pre_rst_valid", pkt_valid_o, 1);
    check_eq("pre_rst_count", frame_count_o, 1);
    reset_i = 1'b1;
    step();
    check_eq("mid_rst_rx_ready", rx_ready_o, 1);
    check_eq("mid_rst_valid", pkt_valid_o, 0);
    check_eq("mid_rst_last", pkt_last_o, 0);
    check_eq("mid_rst_done", pkt_done_o, 0);
    check_eq("mid_rst_err", err_o, 0);
    check_eq("mid_rst_code", err_code_o, 0);
    check_eq("mid_rst_count", frame_count_o, 0);
    reset_i = 1'b0;
    step();
    check_eq("post_rst_valid", pkt_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
